// File: rtl/disp_pkg.sv
// ============================================================================
// Module : disp_pkg
// Shared types and constants for the 8-digit 7-segment scan controller.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package disp_pkg;

  localparam int N_DIGITS = 8;
  localparam logic [N_DIGITS-1:0] AN_OFF = 8'hFF;

  typedef enum logic {BLANK, DRIVE} scan_state_t;

  typedef logic [4*N_DIGITS-1:0] disp_word_t;

endpackage

`default_nettype wire

// File: rtl/disp_slot_timer.sv
// ============================================================================
// Module : disp_slot_timer
// Per-digit slot counter with end-of-slot and end-of-blank-window strobes.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module disp_slot_timer #(
  parameter int SCAN_DIV     = 12500,
  parameter int BLANK_CYCLES = 100
) (
  input  logic clk_i,
  input  logic rst_n_i,
  output logic end_of_slot_o,
  output logic blank_end_o
);

  localparam int unsigned CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CNT_W-1:0] c_last_cnt   = CNT_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] c_blank_len  = CNT_W'(BLANK_CYCLES);
  localparam logic [CNT_W-1:0] c_blank_last = CNT_W'(BLANK_CYCLES - 1);

  if (SCAN_DIV < 4 || BLANK_CYCLES < 1 || BLANK_CYCLES >= SCAN_DIV) begin : g_param_check
    $error("disp_slot_timer: need SCAN_DIV >= 4 and 1 <= BLANK_CYCLES < SCAN_DIV");
  end

  logic [CNT_W-1:0] slot_cnt_q;
  logic [CNT_W-1:0] slot_cnt_d;
  logic             w_end_of_slot;
  logic             w_in_blank;

  assign w_end_of_slot = (slot_cnt_q == c_last_cnt);
  assign w_in_blank    = (slot_cnt_q < c_blank_len);
  assign slot_cnt_d    = w_end_of_slot ? '0 : slot_cnt_q + 1'b1;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      slot_cnt_q <= '0;
    end else begin
      slot_cnt_q <= slot_cnt_d;
    end
  end

  assign end_of_slot_o = w_end_of_slot;
  assign blank_end_o   = w_in_blank && (slot_cnt_q == c_blank_last);

endmodule

`default_nettype wire

// File: rtl/display_scan_controller.sv
// ============================================================================
// Module : display_scan_controller
// 8-digit common-anode 7-segment scanner with anode dead-time, digit masking
// and frame-atomic value loading. Optional macro: LEADING_ZERO_BLANK_EN.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module display_scan_controller
  import disp_pkg::*;
#(
  parameter int SCAN_DIV     = 12500,
  parameter int BLANK_CYCLES = 100
) (
  input  logic        CLK100MHZ,
  input  logic        reset_n,
  input  logic        load_valid,
  output logic        load_ready,
  input  logic [31:0] load_data,
  input  logic [7:0]  digit_en,
  input  logic [7:0]  dp_in,
  output logic [3:0]  hex_out,
  output logic [7:0]  AN,
  output logic        DP,
  output logic        frame_done
);

  scan_state_t state_q;
  logic [2:0]  idx_q;
  logic [2:0]  idx_d;
  disp_word_t  active_q;
  disp_word_t  pending_q;
  logic        pending_full_q;
  logic [7:0]  an_q;
  logic        dp_q;
  logic [3:0]  hex_q;
  logic        frame_done_q;

  logic w_end_of_slot;
  logic w_blank_end;
  logic w_frame_end;
  logic w_take;
  logic w_lz_blank;
  logic w_digit_on;

  disp_slot_timer #(
    .SCAN_DIV     (SCAN_DIV),
    .BLANK_CYCLES (BLANK_CYCLES)
  ) u_slot_timer (
    .clk_i         (CLK100MHZ),
    .rst_n_i       (reset_n),
    .end_of_slot_o (w_end_of_slot),
    .blank_end_o   (w_blank_end)
  );

  assign idx_d       = idx_q + 3'd1;
  assign w_frame_end = w_end_of_slot && (idx_q == 3'd7);
  assign w_take      = load_valid && !pending_full_q;

`ifdef LEADING_ZERO_BLANK_EN
  // Everything from this digit upward is zero -> it is a leading zero.
  assign w_lz_blank = (idx_q != 3'd0) && ((active_q >> {idx_q, 2'b00}) == '0);
`else
  assign w_lz_blank = 1'b0;
`endif

  assign w_digit_on = digit_en[idx_q] && !w_lz_blank;

  always_ff @(posedge CLK100MHZ or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= BLANK;
      idx_q          <= 3'd0;
      active_q       <= '0;
      pending_q      <= '0;
      pending_full_q <= 1'b0;
      an_q           <= AN_OFF;
      dp_q           <= 1'b1;
      hex_q          <= 4'd0;
      frame_done_q   <= 1'b0;
    end else begin
      hex_q        <= active_q[{idx_q, 2'b00} +: 4];
      frame_done_q <= w_frame_end;

      case (state_q)
        BLANK: begin
          an_q <= AN_OFF;
          dp_q <= 1'b1;
          if (w_blank_end) begin
            state_q <= DRIVE;
          end
        end
        DRIVE: begin
          if (w_digit_on) begin
            an_q <= ~(8'b1 << idx_q);
            dp_q <= ~dp_in[idx_q];
          end else begin
            an_q <= AN_OFF;
            dp_q <= 1'b1;
          end
          if (w_end_of_slot) begin
            state_q <= BLANK;
            idx_q   <= idx_d;
          end
        end
        default: state_q <= BLANK;
      endcase

      // A take needs pending empty and a commit needs it full, so they never collide.
      if (w_take) begin
        pending_q      <= load_data;
        pending_full_q <= 1'b1;
      end else if (w_frame_end && pending_full_q) begin
        active_q       <= pending_q;
        pending_full_q <= 1'b0;
      end
    end
  end

  assign load_ready = !pending_full_q;
  assign hex_out    = hex_q;
  assign AN         = an_q;
  assign DP         = dp_q;
  assign frame_done = frame_done_q;

endmodule

`default_nettype wire
